// File: rtl/axi_slave_regfile_if.sv
// AXI4-Lite bus bundle between axi_master and axi_slave_regfile.
// Carries the five channels signal-for-signal.
interface axi_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_slave_regfile.sv
// AXI4-Lite slave backed by NUM_REGS 32-bit registers with independent read/write FSMs.
// Define AXI_SLAVE_ADDR_ERR_EN to reject out-of-range accesses with SLVERR.
module axi_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_slave_regfile_if.slave  bus
);
    localparam int          IDX_W = $clog2(NUM_REGS);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned NREG  = NUM_REGS;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  live;
    logic                  aw_got, w_got, aw_err;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic awready, wready, bvalid, arready, rvalid;
    logic aw_hs, w_hs, ar_hs, commit;
    logic aw_oor, ar_oor;

`ifdef AXI_SLAVE_ADDR_ERR_EN
    assign aw_oor = (bus.awaddr >= ADDR_WIDTH'(NUM_REGS * 4));
    assign ar_oor = (bus.araddr >= ADDR_WIDTH'(NUM_REGS * 4));
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    assign aw_hs = bus.awvalid && awready;
    assign w_hs  = bus.wvalid  && wready;
    assign ar_hs = bus.arvalid && arready;

    // live holds the readies low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            live     <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            live     <= 1'b1;
        end
    end

    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        commit  = 1'b0;
        unique case (wr_state)
            WR_IDLE: begin
                awready = live && !aw_got;
                wready  = live && !w_got;
                if (aw_got && w_got) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bus.bready) wr_next = WR_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        unique case (rd_state)
            RD_IDLE: begin
                arready = live;
                if (ar_hs) rd_next = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                if (bus.rready) rd_next = RD_IDLE;
            end
        endcase
    end

    // Read sampling uses pre-edge regs, so a same-edge commit returns the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_err  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= '0;
            rresp_q <= '0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_idx <= bus.awaddr[IDX_W+1:2];
                aw_err <= aw_oor;
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
            if (commit) begin
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                bresp_q <= aw_err ? SLVERR : OKAY;
                if (!aw_err) begin
                    for (int unsigned b = 0; b < NB; b++) begin
                        if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
            if (ar_hs) begin
                rdata_q <= ar_oor ? '0 : regs[bus.araddr[IDX_W+1:2]];
                rresp_q <= ar_oor ? SLVERR : OKAY;
            end
        end
    end

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_axi_slave_regfile.sv
// Self-checking bench for axi_slave_regfile against an array-based register model.
// Out-of-range expectations follow AXI_SLAVE_ADDR_ERR_EN.
module tb_axi_slave_regfile;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;
    logic [31:0] model [16];

    axi_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int unsigned idx;
        idx = (a / 4) % 16;
`ifdef AXI_SLAVE_ADDR_ERR_EN
        if (a >= 32'd64) return 2'b10;
`endif
        for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                       output logic [1:0] r);
        int unsigned idx;
        idx = (a / 4) % 16;
        d = model[idx];
        r = 2'b00;
`ifdef AXI_SLAVE_ADDR_ERR_EN
        if (a >= 32'd64) begin
            d = 32'h0;
            r = 2'b10;
        end
`endif
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int bp);
        logic [1:0] er;
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        while (!(aw_done && w_done) && cyc < 60) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1; cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            if (w_done && !aw_done) begin
                nvec++;
                if (bus.wready !== 1'b0) begin
                    nerr++; $display("FAIL wready_after_w got=%b exp=0", bus.wready);
                end
            end
        end
        bus.awvalid = 0; bus.wvalid = 0;
        nvec++;
        if (!(aw_done && w_done)) begin
            nerr++; $display("FAIL wr_handshake addr=%h got=timeout exp=aw+w accepted", addr);
        end
        nvec++;
        if (bus.bvalid !== 1'b0) begin
            nerr++; $display("FAIL bvalid_early got=%b exp=0", bus.bvalid);
        end
        @(posedge clk); #1;
        er = model_write(addr, data, strb);
        nvec++;
        if ({bus.bvalid, bus.bresp} !== {1'b1, er}) begin
            nerr++; $display("FAIL bresp addr=%h got=%b/%b exp=1/%b", addr, bus.bvalid, bus.bresp, er);
        end
        repeat (bp) begin
            @(posedge clk); #1;
            nvec++;
            if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== {1'b1, er, 2'b00}) begin
                nerr++;
                $display("FAIL b_hold got=%b/%b/%b%b exp=1/%b/00", bus.bvalid, bus.bresp,
                         bus.awready, bus.wready, er);
            end
        end
        bus.bready = 1;
        @(posedge clk); #1;
        bus.bready = 0;
        nvec++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
            nerr++; $display("FAIL b_done got=%b%b%b exp=011", bus.bvalid, bus.awready, bus.wready);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int bp);
        logic [31:0] ed;
        logic [1:0]  er;
        bit hs, ah;
        int cyc;
        hs = 0; cyc = 0;
        model_read(addr, ed, er);
        bus.araddr = addr; bus.arvalid = 1;
        while (!hs && cyc < 50) begin
            ah = bus.arready;
            @(posedge clk); #1; cyc++;
            hs = ah;
        end
        bus.arvalid = 0;
        nvec++;
        if (!hs) begin
            nerr++; $display("FAIL ar_handshake addr=%h got=timeout exp=accepted", addr);
        end
        nvec++;
        if ({bus.rvalid, bus.rresp, bus.rdata, bus.arready} !== {1'b1, er, ed, 1'b0}) begin
            nerr++;
            $display("FAIL rdata addr=%h got=v%b r%b d%h ar%b exp=v1 r%b d%h ar0", addr, bus.rvalid,
                     bus.rresp, bus.rdata, bus.arready, er, ed);
        end
        repeat (bp) begin
            @(posedge clk); #1;
            nvec++;
            if ({bus.rvalid, bus.rresp, bus.rdata, bus.arready} !== {1'b1, er, ed, 1'b0}) begin
                nerr++;
                $display("FAIL r_hold got=v%b r%b d%h ar%b exp=v1 r%b d%h ar0", bus.rvalid,
                         bus.rresp, bus.rdata, bus.arready, er, ed);
            end
        end
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        nvec++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            nerr++; $display("FAIL r_done got=%b%b exp=01", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1; #1;
        rst_n = 0; #1;
        nvec++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp,
             bus.rdata} !== '0) begin
            nerr++; $display("FAIL reset_outputs got=%b%b%b%b%b %b %b %h exp=all zero", bus.awready,
                             bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1; #1;
        nvec++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            nerr++; $display("FAIL ready_before_edge got=%b%b%b exp=000", bus.awready, bus.wready, bus.arready);
        end
        @(posedge clk); #1;
        nvec++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            nerr++; $display("FAIL ready_after_edge got=%b%b%b exp=111", bus.awready, bus.wready, bus.arready);
        end
        for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0);
    endtask

    task automatic test_basic_write();
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h04, 0);
    endtask

    task automatic test_w_before_aw();
        do_write(32'h08, 32'h12345678, 4'hF, 3, 0, 0);
        do_read(32'h08, 0);
    endtask

    task automatic test_byte_strobes();
        do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(32'h0C, 32'h00000000, 4'b0101, 1, 0, 0);
        do_read(32'h0C, 0);
        nvec++;
        if (model[3] !== 32'hFF00FF00) begin
            nerr++; $display("FAIL strobe_model got=%h exp=ff00ff00", model[3]);
        end
        do_write(32'h0C, 32'h13572468, 4'h0, 0, 0, 0);
        do_read(32'h0C, 0);
    endtask

    task automatic test_backpressure();
        do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 5);
        do_read(32'h10, 5);
    endtask

    task automatic test_out_of_range();
        do_write(32'h00, 32'h11111111, 4'hF, 0, 0, 0);
        do_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        do_read(32'h40, 0);
        do_read(32'h00, 0);
        do_read(32'h1000_0044, 0);
    endtask

    task automatic test_same_edge();
        logic [31:0] old, nw;
        logic [1:0]  er;
        nw = $urandom;
        old = model[5];
        bus.awaddr = 32'h14; bus.wdata = nw; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        nvec++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            nerr++; $display("FAIL same_edge_ready got=%b%b%b exp=111", bus.awready, bus.wready, bus.arready);
        end
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0;
        bus.araddr = 32'h14; bus.arvalid = 1;
        @(posedge clk); #1;
        bus.arvalid = 0;
        nvec++;
        if ({bus.bvalid, bus.rvalid, bus.rdata} !== {2'b11, old}) begin
            nerr++; $display("FAIL same_edge_read got=b%b r%b d%h exp=b1 r1 d%h", bus.bvalid,
                             bus.rvalid, bus.rdata, old);
        end
        er = model_write(32'h14, nw, 4'hF);
        bus.bready = 1; bus.rready = 1;
        @(posedge clk); #1;
        bus.bready = 0; bus.rready = 0;
        nvec++;
        if ({bus.bvalid, bus.rvalid, bus.bresp} !== {2'b00, er}) begin
            nerr++; $display("FAIL same_edge_done got=%b%b %b exp=00 %b", bus.bvalid, bus.rvalid, bus.bresp, er);
        end
        do_read(32'h14, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3) * 64);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) do_write(32'(n * 4), $urandom, 4'hF, 0, 0, 0);
        for (int n = 0; n < 4; n++) do_read(32'(n * 4), 0);
    endtask

    task automatic test_reset_mid_write();
        do_write(32'h04, 32'h55AA55AA, 4'hF, 0, 0, 0);
        do_read(32'h04, 0);
        bus.awaddr = 32'h04; bus.awvalid = 1;
        @(posedge clk); #1;
        bus.awvalid = 0;
        nvec++;
        if ({bus.awready, bus.wready} !== 2'b01) begin
            nerr++; $display("FAIL aw_captured got=%b%b exp=01", bus.awready, bus.wready);
        end
        rst_n = 0; #1;
        nvec++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp,
             bus.rdata} !== '0) begin
            nerr++; $display("FAIL midreset_outputs got=%b%b%b%b%b %b %b %h exp=all zero", bus.awready,
                             bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        nvec++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            nerr++; $display("FAIL midreset_ready got=%b%b%b exp=111", bus.awready, bus.wready, bus.arready);
        end
        do_read(32'h04, 0);
    endtask

    initial begin
        nvec = 0; nerr = 0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        test_reset();
        test_basic_write();
        test_w_before_aw();
        test_byte_strobes();
        test_backpressure();
        test_out_of_range();
        test_same_edge();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
